lfsr_range_sampler: RTL and testbench

- Downstream consumer and controller of the LFSR block.
- Seeds the LFSR through its load_seed/rand inputs and discards a warm-up run of states.
- Converts the free-running LFSR state into uniformly distributed values in [0, LIMIT-1] by rejection sampling.
- Delivers those values on a valid/ready handshake, and recovers automatically from the all-zero LFSR lock-up state.

---
 rtl/lfsr_range_sampler.sv | 134 +++++++++++++
 tb/tb_lfsr_range_sampler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_range_sampler.sv
// Seeds an external LFSR, discards a warm-up run, and turns its state into uniform samples in [0, LIMIT-1]
// by rejection. Optional rejected-candidate counter is enabled with `define SAMPLER_REJECT_CNT_EN.
module lfsr_range_sampler #(
  parameter int             N            = 17,
  parameter int             LIMIT        = 10,
  parameter int             K            = $clog2(LIMIT),
  parameter int             WARMUP       = 4,
  parameter logic [N-1:0]   DEFAULT_SEED = 17'h1ACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] seed,
  input  logic [N-1:0] lfsr_num,
  output logic         lfsr_load,
  output logic [N-1:0] lfsr_seed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_data,
  output logic         busy,
  output logic         lockup
`ifdef SAMPLER_REJECT_CNT_EN
  ,
  output logic [7:0]   reject_cnt
`endif
);

  localparam int           WCW       = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WCW-1:0] WARM_LAST = WCW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [K:0]   LIMIT_V   = (K+1)'(LIMIT);

  typedef enum logic [2:0] {IDLE, LOAD, WARM, SAMPLE, HOLD} state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] warm_cnt, warm_nxt;
  logic           load_nxt, valid_nxt, busy_nxt, lockup_nxt;
  logic [N-1:0]   seed_nxt;
  logic [K-1:0]   data_nxt;
  logic [K-1:0]   cand;
  logic           cand_ok, lock_det;

  function automatic logic [N-1:0] pick_seed(input logic [N-1:0] s);
    return (s == '0) ? DEFAULT_SEED : s;
  endfunction

`ifdef SAMPLER_REJECT_CNT_EN
  logic [7:0] reject_nxt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  assign cand     = lfsr_num[K-1:0];
  assign cand_ok  = {1'b0, cand} < LIMIT_V;
  // An all-zero LFSR never leaves zero; only states the LFSR actually free-runs through are watched.
  assign lock_det = ((state == WARM) || (state == SAMPLE)) && (lfsr_num == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      warm_cnt   <= '0;
      lfsr_load  <= 1'b0;
      lfsr_seed  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      lockup     <= 1'b0;
`ifdef SAMPLER_REJECT_CNT_EN
      reject_cnt <= '0;
`endif
    end else begin
      state      <= state_nxt;
      warm_cnt   <= warm_nxt;
      lfsr_load  <= load_nxt;
      lfsr_seed  <= seed_nxt;
      out_valid  <= valid_nxt;
      out_data   <= data_nxt;
      busy       <= busy_nxt;
      lockup     <= lockup_nxt;
`ifdef SAMPLER_REJECT_CNT_EN
      reject_cnt <= reject_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        LOAD:    state_nxt = (WARMUP == 0) ? SAMPLE : WARM;
        WARM: begin
          if (lock_det)                   state_nxt = LOAD;
          else if (warm_cnt == WARM_LAST) state_nxt = SAMPLE;
        end
        SAMPLE: begin
          if (lock_det)     state_nxt = LOAD;
          else if (cand_ok) state_nxt = HOLD;
        end
        HOLD:    if (out_ready) state_nxt = SAMPLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    load_nxt   = (state_nxt == LOAD);
    valid_nxt  = (state_nxt == HOLD);
    busy_nxt   = (state_nxt != IDLE);
    warm_nxt   = ((state == WARM) && (state_nxt == WARM)) ? warm_cnt + 1'b1 : '0;
    data_nxt   = ((state == SAMPLE) && (state_nxt == HOLD)) ? cand : out_data;
    seed_nxt   = lfsr_seed;
    lockup_nxt = lockup;
    if (start) begin
      seed_nxt   = pick_seed(seed);
      lockup_nxt = 1'b0;
    end else if (lock_det) begin
      seed_nxt   = DEFAULT_SEED;
      lockup_nxt = 1'b1;
    end
`ifdef SAMPLER_REJECT_CNT_EN
    reject_nxt = reject_cnt;
    if (start)
      reject_nxt = '0;
    else if ((state == SAMPLE) && !lock_det && !cand_ok)
      reject_nxt = sat_inc8(reject_cnt);
`endif
  end

endmodule

// File: tb/tb_lfsr_range_sampler.sv
// Bench for lfsr_range_sampler: directed vector table, real-LFSR lock-up sequence, async reset,
// and randomized traffic against a countdown-based behavioural model.
module tb_lfsr_range_sampler;

  localparam int          LIMIT = 10;
  localparam int          W1    = 4;
  localparam logic [16:0] DEF   = 17'h1ACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, ready0 = 1'b0, start1 = 1'b0, ready1 = 1'b0;
  logic [16:0] seed0 = '0, num0 = '0, seed1 = '0;
  logic        load0, valid0, busy0, lock0, load1, valid1, busy1, lock1;
  logic [16:0] lseed0, lseed1, lfsr;
  logic [3:0]  data0, data1;
`ifdef SAMPLER_REJECT_CNT_EN
  logic [7:0]  rej0, rej1;
`endif

  lfsr_range_sampler #(.N(17), .LIMIT(LIMIT), .WARMUP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .seed(seed0), .lfsr_num(num0),
    .lfsr_load(load0), .lfsr_seed(lseed0), .out_valid(valid0), .out_ready(ready0),
    .out_data(data0), .busy(busy0), .lockup(lock0)
`ifdef SAMPLER_REJECT_CNT_EN
    , .reject_cnt(rej0)
`endif
  );

  lfsr_range_sampler #(.N(17), .LIMIT(LIMIT), .WARMUP(W1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .seed(seed1), .lfsr_num(lfsr),
    .lfsr_load(load1), .lfsr_seed(lseed1), .out_valid(valid1), .out_ready(ready1),
    .out_data(data1), .busy(busy1), .lockup(lock1)
`ifdef SAMPLER_REJECT_CNT_EN
    , .reject_cnt(rej1)
`endif
  );

  // Stand-in LFSR: states with bits 16..13 clear drain to zero, so seed 1 locks after one shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       lfsr <= '0;
    else if (load1) lfsr <= lseed1;
    else            lfsr <= {lfsr[16] ^ lfsr[13], lfsr[16:1]};
  end

  typedef struct {
    bit          busy;
    bit          load;
    bit          valid;
    bit          lock;
    logic [16:0] seed;
    logic [3:0]  data;
    int          gap;
    int          rej;
  } mdl_t;

  typedef struct {
    bit          st;
    logic [16:0] sd;
    logic [16:0] num;
    bit          rdy;
    bit          e_load;
    logic [16:0] e_seed;
    bit          e_valid;
    logic [3:0]  e_data;
    bit          e_lock;
    int          e_rej;
  } vec_t;

  mdl_t m0, m1;
  vec_t tbl[18];
  int   checks = 0;
  int   errors = 0;

  function automatic mdl_t mreset();
    mdl_t m;
    m.busy = 0; m.load = 0; m.valid = 0; m.lock = 0;
    m.seed = '0; m.data = '0; m.gap = 0; m.rej = 0;
    return m;
  endfunction

  // gap = cycles left before candidates are examined (load cycle plus warm-up).
  function automatic mdl_t mstep(mdl_t m, int w, bit st, logic [16:0] sd, logic [16:0] num, bit rdy);
    mdl_t n = m;
    n.load = 0;
    if (st) begin
      n.busy = 1; n.load = 1; n.valid = 0; n.lock = 0; n.rej = 0;
      n.seed = (sd == 0) ? DEF : sd;
      n.gap  = 1 + w;
    end else if (m.busy) begin
      if (m.valid) begin
        if (rdy) n.valid = 0;
      end else if (m.load) begin
        n.gap = m.gap - 1;
      end else if (num == 0) begin
        n.lock = 1; n.seed = DEF; n.load = 1; n.gap = 1 + w;
      end else if (m.gap > 0) begin
        n.gap = m.gap - 1;
      end else if ((num % 16) < LIMIT) begin
        n.valid = 1; n.data = num[3:0];
      end else if (m.rej < 255) begin
        n.rej = m.rej + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [7:0] rejv(int r);
`ifdef SAMPLER_REJECT_CNT_EN
    return 8'(r);
`else
    return 8'(r & 0);
`endif
  endfunction

  function automatic logic [32:0] mvec(mdl_t m);
    return {m.load, m.seed, m.valid, m.data, m.busy, m.lock, rejv(m.rej)};
  endfunction

  function automatic logic [32:0] act0();
`ifdef SAMPLER_REJECT_CNT_EN
    return {load0, lseed0, valid0, data0, busy0, lock0, rej0};
`else
    return {load0, lseed0, valid0, data0, busy0, lock0, 8'd0};
`endif
  endfunction

  function automatic logic [32:0] act1();
`ifdef SAMPLER_REJECT_CNT_EN
    return {load1, lseed1, valid1, data1, busy1, lock1, rej1};
`else
    return {load1, lseed1, valid1, data1, busy1, lock1, 8'd0};
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance one clock: model consumes the inputs applied now, then both DUTs are compared.
  task automatic tick();
    if (rst) begin
      m0 = mstep(m0, 0, start0, seed0, num0, ready0);
      m1 = mstep(m1, W1, start1, seed1, lfsr, ready1);
    end
    @(negedge clk);
    check("model0", 64'(act0()), 64'(mvec(m0)));
    check("model1", 64'(act1()), 64'(mvec(m1)));
  endtask

  task automatic setv(int i, bit st, logic [16:0] sd, logic [16:0] num, bit rdy,
                      bit el, logic [16:0] es, bit ev, logic [3:0] ed, bit elk, int er);
    tbl[i].st = st; tbl[i].sd = sd; tbl[i].num = num; tbl[i].rdy = rdy;
    tbl[i].e_load = el; tbl[i].e_seed = es; tbl[i].e_valid = ev;
    tbl[i].e_data = ed; tbl[i].e_lock = elk; tbl[i].e_rej = er;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int loads, nsamp, bad_range;
    //    i  st  seed       num        rdy load eseed      vld data  lock rej
    setv( 0, 1, 17'h00005, 17'h00000, 0,  1, 17'h00005, 0, 4'd0, 0, 0);
    setv( 1, 0, 17'h00000, 17'h00000, 0,  0, 17'h00005, 0, 4'd0, 0, 0);
    setv( 2, 0, 17'h00000, 17'h0000C, 0,  0, 17'h00005, 0, 4'd0, 0, 1);
    setv( 3, 0, 17'h00000, 17'h00007, 0,  0, 17'h00005, 1, 4'd7, 0, 1);
    setv( 4, 0, 17'h00000, 17'h00003, 0,  0, 17'h00005, 1, 4'd7, 0, 1);
    setv( 5, 0, 17'h00000, 17'h00000, 0,  0, 17'h00005, 1, 4'd7, 0, 1);
    setv( 6, 0, 17'h00000, 17'h1FFFF, 0,  0, 17'h00005, 1, 4'd7, 0, 1);
    setv( 7, 0, 17'h00000, 17'h00009, 0,  0, 17'h00005, 1, 4'd7, 0, 1);
    setv( 8, 0, 17'h00000, 17'h00002, 0,  0, 17'h00005, 1, 4'd7, 0, 1);
    setv( 9, 0, 17'h00000, 17'h00004, 1,  0, 17'h00005, 0, 4'd7, 0, 1);
    setv(10, 0, 17'h00000, 17'h1000A, 0,  0, 17'h00005, 0, 4'd7, 0, 2);
    setv(11, 0, 17'h00000, 17'h00009, 0,  0, 17'h00005, 1, 4'd9, 0, 2);
    setv(12, 1, 17'h00000, 17'h00000, 0,  1, DEF,       0, 4'd9, 0, 0);
    setv(13, 0, 17'h00000, 17'h00000, 0,  0, DEF,       0, 4'd9, 0, 0);
    setv(14, 0, 17'h00000, 17'h00000, 0,  1, DEF,       0, 4'd9, 1, 0);
    setv(15, 0, 17'h00000, 17'h00003, 0,  0, DEF,       0, 4'd9, 1, 0);
    setv(16, 0, 17'h00000, 17'h00003, 0,  0, DEF,       1, 4'd3, 1, 0);
    setv(17, 1, 17'h00022, 17'h00005, 1,  1, 17'h00022, 0, 4'd3, 0, 0);

    m0 = mreset();
    m1 = mreset();
    #1 rst = 1'b0;
    #2;
    check("reset0", 64'(act0()), 64'd0);
    check("reset1", 64'(act1()), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      start0 = tbl[i].st; seed0 = tbl[i].sd; num0 = tbl[i].num; ready0 = tbl[i].rdy;
      tick();
      check($sformatf("vec%0d", i), 64'(act0()),
            64'({tbl[i].e_load, tbl[i].e_seed, tbl[i].e_valid, tbl[i].e_data, 1'b1,
                 tbl[i].e_lock, rejv(tbl[i].e_rej)}));
    end
    start0 = 1'b0; ready0 = 1'b0;

    // Reset asserted between clock edges while dut0 sits in SAMPLE rejecting.
    num0 = 17'h0000F;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    check("async_rst0", 64'(act0()), 64'd0);
    check("async_rst1", 64'(act1()), 64'd0);
    m0 = mreset();
    m1 = mreset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("busy_after_rst", 64'(busy0), 64'd0);

    // Seed 1 on the real LFSR drains to zero during warm-up.
    start1 = 1'b1; seed1 = 17'h00001; ready1 = 1'b1;
    tick();
    start1 = 1'b0;
    loads = load1 ? 1 : 0;
    nsamp = 0;
    bad_range = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (load1) loads++;
      if (valid1) begin
        nsamp++;
        if (data1 >= LIMIT) bad_range++;
      end
    end
    check("lock_loads", 64'(loads), 64'd2);
    check("lock_flag", 64'(lock1), 64'd1);
    check("lock_seed", 64'(lseed1), 64'(DEF));
    check("lock_samples", 64'(nsamp >= 3), 64'd1);
    check("lock_range", 64'(bad_range), 64'd0);

    for (int c = 0; c < 3000; c++) begin
      int r;
      start0 = ($urandom % 64) == 0;
      seed0  = (($urandom % 4) == 0) ? 17'h0 : 17'($urandom);
      r = $urandom % 8;
      num0   = (r == 0) ? 17'h0 : (r == 1) ? 17'($urandom % 16) : 17'($urandom);
      ready0 = ($urandom % 2) == 1;
      start1 = ($urandom % 150) == 0;
      r = $urandom % 4;
      seed1  = (r == 0) ? 17'h0 : (r == 1) ? 17'($urandom % 32'h2000) : 17'($urandom);
      ready1 = ($urandom % 3) != 0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
